bnn_stream_cfu: RTL and testbench
=================================

Name: bnn_stream_cfu

Overview:
- Streaming (CFU-L2, valid/ready) binary-neural-net dot-product custom function unit.
- Each request carries two DATA_W-bit operands. The response is the XNOR-popcount `popcount(~(data0 ^ data1))`, zero-extended to DATA_W.
- Internally a combinational CFU-L0 core computes the result. A one-entry L0→L2 adapter registers the response and provides valid/ready flow control.
- Sits on the CPU's CFU request/response bus.

Parameters:
- CFU_DATA_W, 32, operand/result width; legal values 32 or 64 only; any other value triggers an elaboration-time check failure.
- CFU_N_CFUS, 1, number of CFUs; must be 1.
- CFU_N_STATES, 0, must be 0; no state-context field.
- CFU_FUNC_ID_W, 0, must be 0; single function, no function-ID field.
- CFU_INSN_W, 0, must be 0; no raw-instruction field.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- clk_en  input  1  clock enable; when low, all registers hold.
- req_valid  input  1  request valid.
- req_ready  output  1  request ready.
- req_data0  input  CFU_DATA_W  operand a.
- req_data1  input  CFU_DATA_W  operand b.
- resp_valid  output  1  response valid.
- resp_ready  input  1  response consumer ready.
- resp_status  output  3  response status; CFU_OK = 0.
- resp_data  output  CFU_DATA_W  popcount result.

Behaviour:
- Reset (rst_n low, asynchronous): resp_valid=0, resp_data=0, resp_status=0. req_ready is combinational and therefore reads 1 during and after reset.
- Core function (combinational):
  - x = ~(req_data0 ^ req_data1).
  - Result = number of 1 bits in x, range 0..DATA_W, zero-extended to DATA_W.
  - Status is always CFU_OK. There are no error codes.
- Adapter (single output register stage):
  - req_ready = !resp_valid || resp_ready. This is combinational; it never depends on req_valid.
  - Request fires when req_valid && req_ready && clk_en at a rising clk edge.
  - Response fires when resp_valid && resp_ready.
  - On request fire: resp_data ← core result, resp_status ← 0, resp_valid ← 1.
  - Else on response fire: resp_valid ← 0. resp_data holds its last value.
  - Request fire and response fire in the same cycle: the new response replaces the old one, and resp_valid stays 1.
  - Latency: exactly 1 cycle from request fire to resp_valid.
  - Throughput: 1 result per cycle while resp_ready stays high.
- Backpressure:
  - resp_valid=1 with resp_ready=0 → req_ready=0.
  - resp_data and resp_status stay stable until consumed.
  - Requests are never dropped or duplicated.
- Operands only need to be valid in the cycle the request fires.
- Reset asserted mid-transaction discards any pending response.
- clk_en low: no state change. resp_valid/resp_data hold, and handshakes do not fire.

Decomposition:
- Shared package (cfu_pkg):
  - CFU status width (3) and CFU_OK = 0.
  - Parameter-check function, used to check DATA_W ∈ {32, 64} and the zero-width field parameters.
- One natural sub-module: bnn_popcount.
  - Combinational; parameter DATA_W.
  - Inputs a, b; output count = popcount(~(a^b)), built as an adder tree.
- The top level holds the handshake register stage.

Test Plan:
- Equal operands: DATA_W=32, data0=data1=0x12345678, resp_ready=1 → one cycle later resp_valid=1, resp_data=32, resp_status=0.
- Complementary operands: data0=0xFFFFFFFF, data1=0x00000000 → resp_data=0. Then data0=0x0000FFFF, data1=0x00000000 → 16.
- Back-to-back throughput: 4 consecutive requests with resp_ready=1 → 4 consecutive resp_valid cycles, results in order, req_ready constantly 1.
- Backpressure: issue request; hold resp_ready=0 for 3 cycles → req_ready=0, resp_data stable. Raise resp_ready while a new request is pending → old response consumed and new request accepted in the same cycle; next cycle shows the new result.
- 64-bit configuration: DATA_W=64, data0=0xAAAAAAAAAAAAAAAA, data1=0x5555555555555555 → 0. With data1=data0 → 64.
- Reset and clock enable:
  - Assert rst_n=0 with resp_valid=1 → resp_valid drops immediately, without waiting for a clock edge.
  - clk_en=0 during a pending request → no acceptance; acceptance happens on the first enabled edge.

Source files
------------

// File: rtl/cfu_pkg.sv
// Shared CFU definitions: response status encoding and the parameter legality check
// used by CFU tops at elaboration.
package cfu_pkg;

  localparam int unsigned CFU_STATUS_W = 3;
  localparam logic [CFU_STATUS_W-1:0] CFU_OK = '0;

  // True when the parameter set is one this CFU family supports.
  function automatic bit cfu_params_ok(
    input int unsigned data_w,
    input int unsigned n_cfus,
    input int unsigned n_states,
    input int unsigned func_id_w,
    input int unsigned insn_w
  );
    return ((data_w == 32) || (data_w == 64)) &&
           (n_cfus == 1) && (n_states == 0) &&
           (func_id_w == 0) && (insn_w == 0);
  endfunction

endpackage

// File: rtl/bnn_popcount.sv
// Combinational XNOR-popcount core: count = number of bit positions where a and b agree,
// zero-extended to DATA_W. Built as a balanced adder tree (DATA_W is a power of two).
// Ports:
//   a, b   : DATA_W-bit operands
//   count  : DATA_W-bit result, range 0..DATA_W
module bnn_popcount #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] count
);

  localparam int unsigned LEVELS = $clog2(DATA_W);
  localparam int unsigned CNT_W  = LEVELS + 1;

  logic [DATA_W-1:0] agree;
  assign agree = ~(a ^ b);

  // Level l holds DATA_W>>l partial sums; level 0 is the per-bit agreement flags.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int unsigned N = DATA_W >> l;
    logic [N-1:0][CNT_W-1:0] s;
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_bit
        assign s[i] = CNT_W'(agree[i]);
      end
    end else begin : g_sum
      for (genvar i = 0; i < N; i++) begin : g_add
        assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
      end
    end
  end

  assign count = DATA_W'(g_lvl[LEVELS].s[0]);

endmodule

// File: rtl/bnn_stream_cfu.sv
// Streaming valid/ready BNN dot-product CFU: combinational XNOR-popcount core behind a
// single registered response stage.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   clk_en         : clock enable; registers hold and no handshake fires while low
//   req_valid/ready: request handshake (req_ready is combinational)
//   req_data0/1    : operands, only needed in the accepting cycle
//   resp_valid/ready, resp_status, resp_data : registered response channel
module bnn_stream_cfu
  import cfu_pkg::*;
#(
  parameter int unsigned CFU_DATA_W    = 32,
  parameter int unsigned CFU_N_CFUS    = 1,
  parameter int unsigned CFU_N_STATES  = 0,
  parameter int unsigned CFU_FUNC_ID_W = 0,
  parameter int unsigned CFU_INSN_W    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [CFU_DATA_W-1:0]   req_data0,
  input  logic [CFU_DATA_W-1:0]   req_data1,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [CFU_STATUS_W-1:0] resp_status,
  output logic [CFU_DATA_W-1:0]   resp_data
);

  // Reject unsupported configurations at elaboration.
  if (!cfu_params_ok(CFU_DATA_W, CFU_N_CFUS, CFU_N_STATES, CFU_FUNC_ID_W, CFU_INSN_W))
  begin : g_param_err
    $error("bnn_stream_cfu: unsupported parameter set");
  end

  logic [CFU_DATA_W-1:0] core_result;
  logic                  req_fire;
  logic                  resp_fire;

  bnn_popcount #(
    .DATA_W(CFU_DATA_W)
  ) u_core (
    .a    (req_data0),
    .b    (req_data1),
    .count(core_result)
  );

  // Slot is free when empty or being drained this cycle.
  assign req_ready = !resp_valid || resp_ready;
  assign req_fire  = req_valid && req_ready;
  assign resp_fire = resp_valid && resp_ready;

  // Response register: a new request overwrites, a drain without refill empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_status <= CFU_OK;
    end else if (clk_en) begin
      if (req_fire) begin
        resp_valid  <= 1'b1;
        resp_data   <= core_result;
        resp_status <= CFU_OK;
      end else if (resp_fire) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bnn_stream_cfu.sv
// Scoreboard bench for bnn_stream_cfu (32-bit and 64-bit instances).
module tb_bnn_stream_cfu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;

  logic        req_valid, req_ready, resp_valid, resp_ready;
  logic [31:0] req_data0, req_data1, resp_data;
  logic [2:0]  resp_status;

  logic        req_valid_w, req_ready_w, resp_valid_w, resp_ready_w;
  logic [63:0] req_data0_w, req_data1_w, resp_data_w;
  logic [2:0]  resp_status_w;

  int checks = 0;
  int errors = 0;

  logic [63:0] q32[$];
  logic [63:0] q64[$];

  always #5 clk = ~clk;

  bnn_stream_cfu #(.CFU_DATA_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data0(req_data0), .req_data1(req_data1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_status(resp_status), .resp_data(resp_data)
  );

  bnn_stream_cfu #(.CFU_DATA_W(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .req_valid(req_valid_w), .req_ready(req_ready_w),
    .req_data0(req_data0_w), .req_data1(req_data1_w),
    .resp_valid(resp_valid_w), .resp_ready(resp_ready_w),
    .resp_status(resp_status_w), .resp_data(resp_data_w)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: number of bit positions (below w) where the operands agree.
  function automatic logic [63:0] ref_pop(input logic [63:0] a, input logic [63:0] b, input int w);
    int n = 0;
    for (int i = 0; i < w; i++) if (a[i] == b[i]) n++;
    return 64'(n);
  endfunction

  // 32-bit monitor: checks the presented response against the oldest expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      q32.delete();
    end else begin
      check("valid32", 64'(resp_valid), 64'(q32.size() != 0));
      check("ready32", 64'(req_ready), 64'((q32.size() == 0) || resp_ready));
      if (resp_valid && q32.size() != 0) begin
        check("data32", 64'(resp_data), q32[0]);
        check("status32", 64'(resp_status), 64'(0));
      end
      if (resp_valid && resp_ready && clk_en && q32.size() != 0) void'(q32.pop_front());
    end
  end

  // 64-bit monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      q64.delete();
    end else begin
      check("valid64", 64'(resp_valid_w), 64'(q64.size() != 0));
      if (resp_valid_w && q64.size() != 0) begin
        check("data64", resp_data_w, q64[0]);
        check("status64", 64'(resp_status_w), 64'(0));
      end
      if (resp_valid_w && resp_ready_w && clk_en && q64.size() != 0) void'(q64.pop_front());
    end
  end

  // One 32-bit cycle; entered and left at posedge+1. Expectation is queued once accepted.
  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] b,
                     input logic rr, input logic ce);
    req_valid = v; req_data0 = a; req_data1 = b; resp_ready = rr; clk_en = ce;
    @(negedge clk); #2;
    if (v && req_ready && ce && rst_n) q32.push_back(ref_pop(64'(a), 64'(b), 32));
    @(posedge clk); #1;
  endtask

  task automatic cyc64(input logic v, input logic [63:0] a, input logic [63:0] b, input logic rr);
    req_valid_w = v; req_data0_w = a; req_data1_w = b; resp_ready_w = rr; clk_en = 1'b1;
    @(negedge clk); #2;
    if (v && req_ready_w && rst_n) q64.push_back(ref_pop(a, b, 64));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b0; clk_en = 1'b1;
    req_valid = 1'b0; req_data0 = '0; req_data1 = '0; resp_ready = 1'b1;
    req_valid_w = 1'b0; req_data0_w = '0; req_data1_w = '0; resp_ready_w = 1'b1;
    #1;
    check("rst_valid", 64'(resp_valid), 64'(0));
    check("rst_data", 64'(resp_data), 64'(0));
    check("rst_status", 64'(resp_status), 64'(0));
    check("rst_ready", 64'(req_ready), 64'(1));
    check("rst_valid64", 64'(resp_valid_w), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed values and back-to-back throughput.
    cyc(1, 32'h1234_5678, 32'h1234_5678, 1, 1);
    cyc(1, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1);
    cyc(1, 32'h0000_FFFF, 32'h0000_0000, 1, 1);
    for (int i = 0; i < 4; i++) cyc(1, $urandom, $urandom, 1, 1);
    cyc(0, '0, '0, 1, 1);

    // Backpressure: hold the response, keep a new request pending, then drain and accept together.
    cyc(1, 32'hF0F0_1234, 32'h0F0F_1234, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 32'hDEAD_BEEF, 32'hDEAD_0000, 0, 1);
    cyc(1, 32'hDEAD_BEEF, 32'hDEAD_0000, 1, 1);
    cyc(0, '0, '0, 1, 1);

    // Clock enable: no acceptance while low, acceptance on first enabled edge, held response.
    cyc(1, 32'hAAAA_0000, 32'hAAAA_FFFF, 1, 0);
    cyc(1, 32'hAAAA_0000, 32'hAAAA_FFFF, 1, 0);
    cyc(1, 32'hAAAA_0000, 32'hAAAA_FFFF, 1, 1);
    cyc(0, '0, '0, 1, 0);
    cyc(0, '0, '0, 1, 0);
    cyc(0, '0, '0, 1, 1);

    // Randomized traffic with random backpressure and enable.
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : 32'($urandom);
      cyc(1'($urandom_range(0, 3) != 0), ra, rb,
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) != 0));
    end
    cyc(0, '0, '0, 1, 1);
    cyc(0, '0, '0, 1, 1);

    // Asynchronous reset while a response is pending.
    cyc(1, 32'h1111_2222, 32'h1111_2222, 0, 1);
    check("pend_valid", 64'(resp_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(resp_valid), 64'(0));
    check("arst_data", 64'(resp_data), 64'(0));
    check("arst_ready", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(0, '0, '0, 1, 1);
    cyc(1, 32'h0000_00FF, 32'h0000_0000, 1, 1);
    cyc(0, '0, '0, 1, 1);

    // 64-bit configuration.
    cyc64(1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1);
    cyc64(1, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 1);
    for (int i = 0; i < 8; i++)
      cyc64(1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++) cyc64(0, '0, '0, 1);

    check("drain32", 64'(q32.size()), 64'(0));
    check("drain64", 64'(q64.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
